// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and constants for the scanning channel multiplexer
package mux_pkg;

   typedef enum logic [1:0] {
      S_DIRECT,
      S_SCAN,
      S_EMPTY
   } scan_state_t;

   // Fill pattern for illegal or empty selections; sliced to the data width at use.
   localparam int                    FILL_MAX_W = 64;
   localparam logic [FILL_MAX_W-1:0] FILL_ONES  = '1;

endpackage

// File: rtl/rr_next_sel.sv
// rtl/rr_next_sel.sv - circular search for the next and the lowest set bit of a channel mask
module rr_next_sel
   import mux_pkg::*;
#(
   parameter int N     = 9,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     mask,
   input  logic [SEL_W-1:0] cur,
   output logic [SEL_W-1:0] nxt,
   output logic [SEL_W-1:0] first,
   output logic             any
);

   logic [SEL_W-1:0] idx;

   always_comb begin
      nxt   = cur;
      first = '0;
      idx   = '0;
      any   = |mask;
      // Walk downward so the nearest hit after cur is the one left standing;
      // offset N lands back on cur, covering the single-channel case.
      for (int i = N; i >= 1; i--) begin
         idx = SEL_W'((int'(cur) + i) % N);
         if (mask[idx]) nxt = idx;
      end
      for (int k = N - 1; k >= 0; k--) begin
         idx = SEL_W'(k);
         if (mask[idx]) first = idx;
      end
   end

endmodule

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - registered N-channel mux with direct select and masked auto-scan
module mux_scan_n
   import mux_pkg::*;
#(
   parameter int N     = 9,
   parameter int W     = 4,
   parameter int DWELL = 2,
   parameter int SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N*W-1:0]   d,
   input  logic [SEL_W-1:0] sel,
   input  logic             mode,
   input  logic [N-1:0]     en_mask,
   input  logic             hold,
   output logic [W-1:0]     y,
   output logic [SEL_W-1:0] y_ch,
   output logic             y_valid
);

   localparam int             CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [W-1:0]   FILL     = FILL_ONES[W-1:0];

   scan_state_t      state, state_n;
   logic [SEL_W-1:0] ptr, ptr_n, nxt, first;
   logic             any;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [W-1:0]     y_n;
   logic [SEL_W-1:0] y_ch_n;
   logic             y_valid_n;
   logic [W-1:0]     ch [N];

   for (genvar k = 0; k < N; k++) begin : g_ch
      assign ch[k] = d[k*W +: W];
   end

   rr_next_sel #(.N(N), .SEL_W(SEL_W)) u_rr (
      .mask  (en_mask),
      .cur   (ptr),
      .nxt   (nxt),
      .first (first),
      .any   (any)
   );

   // ptr_n is the channel shown during the coming cycle, so the first scan
   // output already carries the lowest enabled channel.
   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      cnt_n     = cnt;
      y_n       = y;
      y_ch_n    = y_ch;
      y_valid_n = y_valid;
      if (!mode) begin
         state_n = S_DIRECT;
         cnt_n   = '0;
         y_ch_n  = sel;
         if ({1'b0, sel} < (SEL_W+1)'(N)) begin
            y_n       = ch[sel];
            y_valid_n = 1'b1;
         end else begin
            y_n       = FILL;
            y_valid_n = 1'b0;
         end
      end else if (!any) begin
         state_n   = S_EMPTY;
         y_n       = FILL;
         y_valid_n = 1'b0;
      end else begin
         state_n = S_SCAN;
         if (state != S_SCAN) begin
            ptr_n = first;
            cnt_n = '0;
         end else if (!en_mask[ptr]) begin
            ptr_n = nxt;
            cnt_n = '0;
         end else if (!hold) begin
            if (cnt == CNT_LAST) begin
               ptr_n = nxt;
               cnt_n = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         y_n       = ch[ptr_n];
         y_ch_n    = ptr_n;
         y_valid_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_DIRECT;
         ptr     <= '0;
         cnt     <= '0;
         y       <= FILL;
         y_ch    <= '0;
         y_valid <= 1'b0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         cnt     <= cnt_n;
         y       <= y_n;
         y_ch    <= y_ch_n;
         y_valid <= y_valid_n;
      end
   end

endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - self-checking bench for mux_scan_n (vector table, hand sequences, random vs model)
module tb_mux_scan_n;

   localparam int N     = 9;
   localparam int W     = 4;
   localparam int DWELL = 2;
   localparam int SEL_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [N*W-1:0]   d;
   logic [SEL_W-1:0] sel = '0;
   logic             mode = 1'b0;
   logic [N-1:0]     en_mask = '0;
   logic             hold = 1'b0;
   logic [W-1:0]     y;
   logic [SEL_W-1:0] y_ch;
   logic             y_valid;

   logic [W-1:0] dv [N];
   int checks = 0;
   int failures = 0;

   int       m_cur, m_shown;
   bit       m_scan;
   logic [3:0] m_y, m_ch;
   logic     m_v;

   typedef struct {
      logic       mode;
      logic [3:0] sel;
      logic [8:0] mask;
      logic       hold;
      logic [3:0] ey;
      logic [3:0] ech;
      logic       ev;
   } vec_t;
   vec_t vt[$];

   always #5 clk = ~clk;

   always_comb begin
      d = '0;
      for (int k = 0; k < N; k++) d[k*W +: W] = dv[k];
   end

   mux_scan_n #(.N(N), .W(W), .DWELL(DWELL)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (d),
      .sel     (sel),
      .mode    (mode),
      .en_mask (en_mask),
      .hold    (hold),
      .y       (y),
      .y_ch    (y_ch),
      .y_valid (y_valid)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [3:0] ey, input logic [3:0] ech, input logic ev);
      chk({nm, ".y"}, 32'(y), 32'(ey));
      chk({nm, ".y_ch"}, 32'(y_ch), 32'(ech));
      chk({nm, ".y_valid"}, 32'(y_valid), 32'(ev));
   endtask

   function automatic int lowest(input logic [8:0] m);
      for (int k = 0; k < N; k++) if (m[k]) return k;
      return 0;
   endfunction

   function automatic int next_en(input int cur, input logic [8:0] m);
      for (int i = 1; i <= N; i++) if (m[(cur + i) % N]) return (cur + i) % N;
      return cur;
   endfunction

   task automatic model_reset();
      m_scan = 0; m_cur = 0; m_shown = 0;
      m_y = 4'hF; m_ch = 4'h0; m_v = 1'b0;
   endtask

   // Behaviour per edge: counts how many cycles the current channel has been shown.
   task automatic model_step();
      if (!mode) begin
         m_scan = 0;
         m_ch   = sel;
         if (int'(sel) < N) begin m_y = dv[sel]; m_v = 1'b1; end
         else begin m_y = 4'hF; m_v = 1'b0; end
      end else if (en_mask == '0) begin
         m_scan = 0;
         m_y = 4'hF; m_v = 1'b0;
      end else begin
         if (!m_scan) begin
            m_cur = lowest(en_mask); m_shown = 1; m_scan = 1;
         end else if (!en_mask[m_cur]) begin
            m_cur = next_en(m_cur, en_mask); m_shown = 1;
         end else if (!hold) begin
            if (m_shown >= DWELL) begin m_cur = next_en(m_cur, en_mask); m_shown = 1; end
            else m_shown++;
         end
         m_y = dv[m_cur]; m_ch = 4'(m_cur); m_v = 1'b1;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic m, input logic [3:0] s, input logic [8:0] mk, input logic h,
                      input logic [3:0] ech, input logic ev);
      vec_t v;
      v.mode = m; v.sel = s; v.mask = mk; v.hold = h;
      v.ech = ech; v.ev = ev; v.ey = ev ? 4'(ech + 4'd3) : 4'hF;
      vt.push_back(v);
   endtask

   initial begin
      int seq3[8];
      int r;
      seq3 = '{1, 1, 4, 4, 8, 8, 1, 1};
      for (int k = 0; k < N; k++) dv[k] = 4'(k + 3);

      add(0, 5, 9'h000, 0, 5, 1);
      add(0, 12, 9'h000, 0, 12, 0);
      for (int i = 0; i < 20; i++) add(1, 0, 9'h1FF, 0, 4'((i / 2) % 9), 1);
      for (int i = 0; i < 8; i++) add(1, 0, 9'h112, 0, 4'(seq3[i]), 1);
      add(1, 0, 9'h112, 0, 4, 1);
      for (int i = 0; i < 5; i++) add(1, 0, 9'h112, 1, 4, 1);
      add(1, 0, 9'h112, 0, 4, 1);
      add(1, 0, 9'h112, 0, 8, 1);
      add(1, 0, 9'h112, 0, 8, 1);
      add(1, 0, 9'h112, 0, 1, 1);
      add(1, 0, 9'h112, 0, 1, 1);
      add(1, 0, 9'h112, 0, 4, 1);
      add(1, 0, 9'h102, 0, 8, 1);
      add(1, 0, 9'h102, 0, 8, 1);
      add(1, 0, 9'h102, 0, 1, 1);
      add(1, 0, 9'h000, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(1, 0, 9'h020, 0, 5, 1);
      add(0, 2, 9'h020, 0, 2, 1);

      // Direct output before any reset, then an asynchronous reset mid-cycle.
      model_reset();
      sel = 4'd3;
      tick();
      chk_out("pre_reset_direct", 4'd6, 4'd3, 1'b1);
      #3 rst_n = 1'b0;
      #1 chk_out("async_reset", 4'hF, 4'h0, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (vt[i]) begin
         mode = vt[i].mode; sel = vt[i].sel; en_mask = vt[i].mask; hold = vt[i].hold;
         tick();
         chk_out($sformatf("vec%0d", i), vt[i].ey, vt[i].ech, vt[i].ev);
      end

      // Live data: a change on the displayed channel appears one cycle later.
      mode = 1'b1; sel = 4'd0; en_mask = 9'h112; hold = 1'b0;
      tick(); chk_out("live_a", 4'd4, 4'd1, 1'b1);
      tick(); chk_out("live_b", 4'd4, 4'd1, 1'b1);
      tick(); chk_out("live_c", 4'd7, 4'd4, 1'b1);
      dv[4] = 4'hA;
      tick(); chk_out("live_d", 4'hA, 4'd4, 1'b1);
      dv[4] = 4'd7;
      tick(); chk_out("live_e", 4'hB, 4'd8, 1'b1);

      // Reset pulse during scan, then restart from the lowest enabled channel.
      #3 rst_n = 1'b0;
      #1 chk_out("scan_reset", 4'hF, 4'h0, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      chk_out("scan_reset_held", 4'hF, 4'h0, 1'b0);
      rst_n = 1'b1;
      tick(); chk_out("scan_restart", 4'd4, 4'd1, 1'b1);

      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         mode = (r < 8) ? 1'b0 : 1'b1;
         sel = 4'($urandom_range(0, 15));
         r = int'($urandom_range(0, 99));
         if (r < 3) en_mask = '0;
         else if (r < 10) en_mask = 9'(1 << $urandom_range(0, 8));
         else if (r < 25) en_mask = 9'($urandom);
         hold = ($urandom_range(0, 99) < 20);
         if ($urandom_range(0, 3) == 0) dv[$urandom_range(0, 8)] = 4'($urandom);
         tick();
         chk_out($sformatf("rnd%0d", i), m_y, m_ch, m_v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
